// File: rtl/hazard_scoreboard.sv
// Hazard control for the D/E pipeline: per-register ready countdown, shadow
// E/M/W destination pipe, RET drain FSM -> forwarding selects and stall/flush.
// Latency: all controls combinational in the same cycle; state updates on clk rising edge.
// Backpressure: stalls F/D on data hazards, holds F and flushes D during RET drain.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   d_valid, d_second_byte        Decode holds an instruction / its immediate byte
//   d_rs, d_rt, d_uses_rs/rt      Decode source registers and whether they are read
//   d_rd, d_reg_write             Decode destination register and write enable
//   d_is_load, d_is_2byte         memory load / non-forwardable 2-byte (LDM) result
//   d_is_ret                      RET/RTI in Decode
//   e_branch_taken                branch resolved taken in Execute
//   fwd_a, fwd_b                  E operand select: 00 regfile, 10 M result, 01 W result
//   stall_f, stall_d              hold PC / IF-ID register
//   flush_d, flush_e              load a bubble into IF-ID / ID-EX register
//
// Build option: define HAZARD_RF_WRITE_THROUGH_EN when the register file
// returns same-cycle write data; 2-byte results then become readable one cycle sooner.

module hazard_scoreboard #(
    parameter int REG_AW    = 2,
    parameter int LOAD_LAT  = 1,
    parameter int RET_DRAIN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic              d_second_byte,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_uses_rs,
    input  logic              d_uses_rt,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_reg_write,
    input  logic              d_is_load,
    input  logic              d_is_2byte,
    input  logic              d_is_ret,
    input  logic              e_branch_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e
);

    localparam int NUM_REGS = 2**REG_AW;

`ifdef HAZARD_RF_WRITE_THROUGH_EN
    // Consumer may read in the same cycle the producer writes back.
    localparam logic [2:0] NWB = 3'd2;
`else
    // Consumer must wait until the producer has left W.
    localparam logic [2:0] NWB = 3'd3;
`endif

    localparam logic [2:0] LOAD_N   = 3'(LOAD_LAT);
    localparam logic [2:0] RET_LOAD = 3'(RET_DRAIN - 1);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              fwd_ok;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              second;
    } e_stage_t;

    // M and W only need destination info for forwarding.
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              fwd_ok;
    } mw_stage_t;

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } ret_state_t;

    e_stage_t   e_q;
    e_stage_t   e_next;
    mw_stage_t  m_q;
    mw_stage_t  w_q;

    logic [2:0] cnt [NUM_REGS];
    logic [2:0] cnt_set;

    ret_state_t ret_state;
    logic [2:0] ret_cnt;

    logic       rs_busy;
    logic       rt_busy;
    logic       data_hazard;
    logic       ret_active;
    logic       issue;

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input mw_stage_t m,
                                           input mw_stage_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (m.vld && m.wr && m.fwd_ok && (m.rd == src)) begin
            sel = 2'b10;
        end else if (w.vld && w.wr && w.fwd_ok && (w.rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign rs_busy     = d_uses_rs && (cnt[d_rs] != 3'd0);
    assign rt_busy     = d_uses_rt && (cnt[d_rt] != 3'd0);
    assign data_hazard = d_valid && !d_second_byte && (rs_busy || rt_busy);

    // The RET itself holds F from the cycle it sits in D, before the FSM moves.
    assign ret_active  = (ret_state == S_DRAIN) || (d_valid && d_is_ret);

    // Single-winner priority: RET drain, then taken branch, then data hazard.
    // Reset forces every control low even while D inputs are still active.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst) begin
            if (ret_active) begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end else if (e_branch_taken) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (data_hazard) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign issue = d_valid && !d_second_byte && !stall_d && !flush_e;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (e_q.vld && !e_q.second) begin
            fwd_a = fwd_sel(e_q.rs, m_q, w_q);
            fwd_b = fwd_sel(e_q.rt, m_q, w_q);
        end
    end

    // ------------------------------------------------------------------
    // Shadow pipe
    // ------------------------------------------------------------------
    always_comb begin
        e_next = '0;
        if (issue) begin
            e_next.vld    = 1'b1;
            e_next.rd     = d_rd;
            e_next.wr     = d_reg_write;
            e_next.fwd_ok = !d_is_2byte;
            e_next.rs     = d_rs;
            e_next.rt     = d_rt;
            e_next.second = d_second_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_next;
            m_q <= '{vld: e_q.vld, rd: e_q.rd, wr: e_q.wr, fwd_ok: e_q.fwd_ok};
            w_q <= m_q;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        cnt_set = 3'd0;
        if (d_is_load) begin
            cnt_set = LOAD_N;
        end else if (d_is_2byte) begin
            cnt_set = NWB;
        end
    end

    // A new writer never shortens an outstanding countdown on the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (issue && d_reg_write && (d_rd == REG_AW'(i))) begin
                    cnt[i] <= (sat_dec(cnt[i]) > cnt_set) ? sat_dec(cnt[i]) : cnt_set;
                end else begin
                    cnt[i] <= sat_dec(cnt[i]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RET drain FSM: the RET cycle itself plus RET_DRAIN-1 cycles in DRAIN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_state <= S_IDLE;
            ret_cnt   <= 3'd0;
        end else begin
            case (ret_state)
                S_IDLE: begin
                    if (issue && d_is_ret && (RET_DRAIN > 1)) begin
                        ret_state <= S_DRAIN;
                        ret_cnt   <= RET_LOAD;
                    end
                end
                S_DRAIN: begin
                    ret_cnt <= sat_dec(ret_cnt);
                    if (ret_cnt <= 3'd1) begin
                        ret_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against a cycle-stamped reference model (ready times, issue log).
// Outputs are sampled on the falling edge; inputs change just after rising edges.

module tb_hazard_scoreboard;

    localparam int REG_AW    = 2;
    localparam int NUM_REGS  = 4;
    localparam int LOAD_LAT  = 1;
    localparam int RET_DRAIN = 3;
`ifdef HAZARD_RF_WRITE_THROUGH_EN
    localparam int NWB = 2;
`else
    localparam int NWB = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       d_valid, d_second_byte;
    logic [1:0] d_rs, d_rt, d_rd;
    logic       d_uses_rs, d_uses_rt, d_reg_write;
    logic       d_is_load, d_is_2byte, d_is_ret, e_branch_taken;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, flush_d, flush_e;

    logic [7:0] ctl;
    logic [3:0] ctrl4;
    assign ctl   = {fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e};
    assign ctrl4 = {stall_f, stall_d, flush_d, flush_e};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_AW    (REG_AW),
        .LOAD_LAT  (LOAD_LAT),
        .RET_DRAIN (RET_DRAIN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .d_valid        (d_valid),
        .d_second_byte  (d_second_byte),
        .d_rs           (d_rs),
        .d_rt           (d_rt),
        .d_uses_rs      (d_uses_rs),
        .d_uses_rt      (d_uses_rt),
        .d_rd           (d_rd),
        .d_reg_write    (d_reg_write),
        .d_is_load      (d_is_load),
        .d_is_2byte     (d_is_2byte),
        .d_is_ret       (d_is_ret),
        .e_branch_taken (e_branch_taken),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e)
    );

    // ------------------------------------------------------------------
    // Reference model: absolute cycle at which each register is readable,
    // the cycle the RET drain ends, and a log of issued instructions.
    // ------------------------------------------------------------------
    typedef struct {
        int cyc;
        int rd;
        bit wr;
        bit fwd_ok;
        int rs;
        int rt;
    } rec_t;

    rec_t       log_q[$];
    int         ready[NUM_REGS];
    int         now = 0;
    int         ret_until = 0;
    logic [7:0] x_ctl;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) ready[i] = 0;
        ret_until = 0;
        log_q.delete();
    endtask

    function automatic int find_issue(int c);
        foreach (log_q[i]) if (log_q[i].cyc == c) return i;
        return -1;
    endfunction

    function automatic logic [1:0] src_sel(int src, int im, int iw);
        if (im >= 0 && log_q[im].wr && log_q[im].fwd_ok && log_q[im].rd == src) return 2'b10;
        if (iw >= 0 && log_q[iw].wr && log_q[iw].fwd_ok && log_q[iw].rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_expect();
        bit hz, ret_act;
        logic [3:0] c;
        logic [1:0] fa, fb;
        int ie, im, iw;
        x_ctl = 8'h00;
        if (rst) return;
        hz = d_valid && !d_second_byte &&
             ((d_uses_rs && ready[d_rs] > now) || (d_uses_rt && ready[d_rt] > now));
        ret_act = (now < ret_until) || (d_valid && d_is_ret);
        if (ret_act)             c = 4'b1010;
        else if (e_branch_taken) c = 4'b0011;
        else if (hz)             c = 4'b1101;
        else                     c = 4'b0000;
        ie = find_issue(now - 1);
        im = find_issue(now - 2);
        iw = find_issue(now - 3);
        fa = 2'b00;
        fb = 2'b00;
        if (ie >= 0) begin
            fa = src_sel(log_q[ie].rs, im, iw);
            fb = src_sel(log_q[ie].rt, im, iw);
        end
        x_ctl = {fa, fb, c};
    endtask

    task automatic model_step();
        bit   iss;
        int   n;
        rec_t r;
        if (rst) begin
            model_reset();
            now++;
            return;
        end
        model_expect();
        iss = d_valid && !d_second_byte && !x_ctl[2] && !x_ctl[0];
        if (iss) begin
            r.cyc = now; r.rd = int'(d_rd); r.wr = d_reg_write;
            r.fwd_ok = !d_is_2byte; r.rs = int'(d_rs); r.rt = int'(d_rt);
            log_q.push_back(r);
            if (d_reg_write) begin
                n = d_is_load ? LOAD_LAT : (d_is_2byte ? NWB : 0);
                if (now + 1 + n > ready[d_rd]) ready[d_rd] = now + 1 + n;
            end
            if (d_is_ret && now >= ret_until) ret_until = now + RET_DRAIN;
        end
        now++;
        while (log_q.size() > 0 && log_q[0].cyc < now - 4) void'(log_q.pop_front());
    endtask

    // ------------------------------------------------------------------
    // Stimulus plumbing
    // ------------------------------------------------------------------
    task automatic drive(input bit v, input bit sb, input bit [1:0] rs, input bit urs,
                         input bit [1:0] rt, input bit urt, input bit [1:0] rd, input bit wr,
                         input bit ld, input bit two, input bit ret, input bit br);
        d_valid = v; d_second_byte = sb; d_rs = rs; d_uses_rs = urs;
        d_rt = rt; d_uses_rt = urt; d_rd = rd; d_reg_write = wr;
        d_is_load = ld; d_is_2byte = two; d_is_ret = ret; e_branch_taken = br;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        model_expect();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            nop();
            tick();
        end
    endtask

    // Measures consecutive stall cycles (inputs held); ends at the falling edge
    // of the first non-stalled cycle. Bounded so a stuck stall cannot hang.
    task automatic count_stalls(output int n);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            settle();
            if (!stall_d) break;
            n++;
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL reset_outputs got %b want 00000000", ctl); end
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL post_reset_idle got %b want 00000000", ctl); end
        tick();
    endtask

    task automatic test_alu_forward();
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);          // ALU R1 <-
        tick();
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);          // reads R1
        settle();
        checks++;
        if (stall_d !== 1'b0) begin errors++; $display("FAIL alu_no_stall got %b want 0", stall_d); end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_a !== 2'b10) begin errors++; $display("FAIL alu_fwd_m got %b want 10", fwd_a); end
        tick();
        idle(4);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);          // ALU R1 <-
        tick();
        drive(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);          // unrelated R2 <-
        tick();
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);          // reads R1 on rt
        tick();
        nop();
        settle();
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0001) begin
            errors++; $display("FAIL alu_fwd_w got %b want 0001", {fwd_a, fwd_b});
        end
        tick();
    endtask

    task automatic test_load_use();
        int n;
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);          // load R2
        tick();
        drive(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);          // reads R2
        settle();
        checks++;
        if (ctrl4 !== 4'b1101) begin errors++; $display("FAIL load_stall_pattern got %b want 1101", ctrl4); end
        tick();
        count_stalls(n);
        n = n + 1;
        checks++;
        if (n !== LOAD_LAT) begin errors++; $display("FAIL load_stall_count got %0d want %0d", n, LOAD_LAT); end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_a !== 2'b01) begin errors++; $display("FAIL load_fwd_w got %b want 01", fwd_a); end
        tick();
    endtask

    task automatic test_ldm();
        int n;
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);          // LDM R3
        tick();
        drive(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);          // immediate consumer
        count_stalls(n);
        checks++;
        if (n !== NWB) begin errors++; $display("FAIL ldm_stall_count got %0d want %0d", n, NWB); end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_a !== 2'b00) begin errors++; $display("FAIL ldm_no_fwd got %b want 00", fwd_a); end
        tick();
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);          // LDM R3
        tick();
        drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);          // its immediate byte
        settle();
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL ldm_second_byte got %b want 00000000", ctl); end
        tick();
        drive(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        count_stalls(n);
        checks++;
        if (n !== NWB - 1) begin errors++; $display("FAIL ldm_after_second got %0d want %0d", n, NWB - 1); end
        tick();
    endtask

    task automatic test_ret();
        int n;
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);          // load R2
        tick();
        drive(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1);          // RET + hazard + branch
        settle();
        checks++;
        if (ctrl4 !== 4'b1010) begin errors++; $display("FAIL ret_first got %b want 1010", ctrl4); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);          // branch keeps asserting
        n = 1;
        for (int k = 0; k < 12; k++) begin
            settle();
            if (!(stall_f && flush_d && !flush_e)) break;
            n++;
            tick();
        end
        checks++;
        if (n !== RET_DRAIN) begin errors++; $display("FAIL ret_drain_len got %0d want %0d", n, RET_DRAIN); end
        checks++;
        if (ctrl4 !== 4'b0011) begin errors++; $display("FAIL ret_after_drain got %b want 0011", ctrl4); end
        tick();
    endtask

    task automatic test_branch();
        int n;
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);          // LDM R3
        tick();
        drive(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1);          // hazarding consumer + branch
        settle();
        checks++;
        if (ctrl4 !== 4'b0011) begin errors++; $display("FAIL branch_flush got %b want 0011", ctrl4); end
        tick();
        drive(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (stall_d !== 1'b1) begin errors++; $display("FAIL branch_sb_kept got %b want 1", stall_d); end
        tick();
        count_stalls(n);
        tick();
    endtask

    task automatic test_reset_mid_drain();
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);          // LDM R1
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);          // RET
        tick();
        nop();
        #1;
        checks++;
        if ({stall_f, flush_d} !== 2'b11) begin
            errors++; $display("FAIL drain_before_rst got %b want 11", {stall_f, flush_d});
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL rst_mid_drain got %b want 00000000", ctl); end
        tick();
        rst = 1'b0;
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);          // reads R1
        settle();
        checks++;
        if (ctrl4 !== 4'b0000) begin errors++; $display("FAIL post_rst_consumer got %b want 0000", ctrl4); end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            int  kind;
            bit  v;
            kind = $urandom_range(0, 3);
            v    = ($urandom_range(0, 9) < 8);
            rst  = ($urandom_range(0, 149) == 0);
            drive(v, ($urandom_range(0, 9) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  (kind == 1), (kind == 2),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
            settle();
            checks++;
            if (ctl !== x_ctl) begin
                errors++; $display("FAIL random step %0d ctl got %b want %b", k, ctl, x_ctl);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        nop();
        model_reset();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_ldm();
        test_ret();
        test_branch();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline's combinational hazard logic. It keeps a per-register ready-countdown scoreboard, a shadow E/M/W pipeline of destination info, and a RET drain state machine. From these it generates forwarding selects for the Execute stage and stall/flush controls for Fetch, Decode and Execute. It sits beside the Decode/Execute pipeline registers and is the only source of hazard control in the core.

## Interface
Parameters:
- `REG_AW`, 2: register-address width; `NUM_REGS = 2**REG_AW`.
- `LOAD_LAT`, 1: bubbles required after a memory load before a dependent instruction may enter E (1..4).
- `RET_DRAIN`, 3: cycles Fetch is held and Decode flushed per RET/RTI (1..7).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `d_valid` in 1: Decode holds a real instruction; low means bubble.
- `d_second_byte` in 1: Decode holds the immediate byte of a 2-byte instruction; it is never stalled.
- `d_rs`, `d_rt` in REG_AW: Decode source registers.
- `d_uses_rs`, `d_uses_rt` in 1: source is actually read.
- `d_rd` in REG_AW: Decode destination register.
- `d_reg_write` in 1: Decode instruction writes `d_rd`.
- `d_is_load` in 1: memory load.
- `d_is_2byte` in 1: result is not forwardable (LDM class).
- `d_is_ret` in 1: RET/RTI.
- `e_branch_taken` in 1: branch resolved taken in Execute.
- `fwd_a`, `fwd_b` out 2: operand select for E. `00` = register file, `10` = M result, `01` = W result.
- `stall_f`, `stall_d` out 1: active-high hold of the PC and IF/ID registers.
- `flush_d`, `flush_e` out 1: active-high; the named pipeline register loads a bubble.

## Operation
- Issue is `d_valid & !d_second_byte & !stall_d & !flush_e`. Issue is the D→E transfer.
- Shadow pipe, per stage {valid, rd, wr, fwd_ok, rs, rt, second}:
  - On issue, load E from the D inputs, with `fwd_ok = !d_is_2byte`.
  - Otherwise E is loaded invalid.
  - E→M and M→W shift every cycle.
- Scoreboard `cnt[r]` (3 bits):
  - On issue with `d_reg_write`, set `cnt[d_rd] = max(cnt[d_rd]-1, N)`.
  - N = `LOAD_LAT` for a load, `NWB` for a 2-byte instruction, 0 otherwise.
  - All other nonzero counters decrement by 1 per cycle and saturate at 0.
- Data hazard: `d_valid & !d_second_byte & ((d_uses_rs & cnt[d_rs]!=0) | (d_uses_rt & cnt[d_rt]!=0))`.
- Forwarding, A shown (B identical with rt):
  - If E is valid and not `second`: `10` when M is valid & wr & fwd_ok & rd==E.rs.
  - Else `01` when W is valid & wr & fwd_ok & rd==E.rs.
  - Else `00`.
  - Register 0 is not special.
- RET FSM, states IDLE and DRAIN, with a 3-bit counter:
  - IDLE→DRAIN when `d_valid & d_is_ret` issues; counter loads RET_DRAIN-1.
  - DRAIN decrements the counter and returns to IDLE at 0.
  - With RET_DRAIN=1, the FSM stays in IDLE.
- Priority, one branch wins per cycle:
  1. RET active (IDLE with `d_valid & d_is_ret`, or DRAIN): `stall_f=1`, `flush_d=1`, `stall_d=0`, `flush_e=0`.
  2. Else `e_branch_taken`: `flush_d=1`, `flush_e=1`.
  3. Else data hazard: `stall_f=1`, `stall_d=1`, `flush_e=1`.
  4. Else all four controls are 0.
- A taken branch does not clear the scoreboard. Flushed instructions never issued, so they never set it.

## Timing
- All control outputs are combinational from the D inputs and registered state, and are valid in the same cycle.
- The scoreboard, shadow pipe and FSM update on the rising edge of `clk`.
- Reset:
  - Shadow pipe is invalid, all `cnt` are 0, FSM is IDLE.
  - Outputs therefore read `fwd_a=fwd_b=00` and `stall_f=stall_d=flush_d=flush_e=0`.
  - A reset mid-drain or mid-stall aborts it immediately.
- Load-use with LOAD_LAT=1: exactly 1 bubble, then the consumer gets `fwd=01` (W) in E.
- Back-to-back writers to the same rd: the longer remaining countdown wins. The counter never shortens.

## Configuration
- `HAZARD_RF_WRITE_THROUGH_EN`:
  - Defined: the register file returns data written in the same cycle, so `NWB = 2` (consumer waits until the producer is in W).
  - Undefined: `NWB = 3` (consumer waits until the producer has left W).
  - No other behaviour changes.

## Test plan
- ALU `R1←` then consumer reading R1 next cycle -> no stall, `fwd_a=10` in E. With one unrelated instruction between -> `fwd_a=01`.
- Load R2 then consumer of R2 (LOAD_LAT=1) -> `stall_f=stall_d=flush_e=1` for 1 cycle, then `fwd=01`. With LOAD_LAT=3 -> 3 stall cycles.
- LDM R3 then consumer of R3 -> 3 stall cycles without the macro, 2 with it. The second byte is never stalled, and `fwd` stays `00` for the LDM itself.
- RET in D (RET_DRAIN=3) -> `stall_f=flush_d=1` for exactly 3 cycles. A coincident data hazard and `e_branch_taken` are ignored.
- `e_branch_taken` with a hazarding consumer in D -> `flush_d=flush_e=1`, `stall_d=0`, scoreboard unchanged.
- Assert `rst` during RET drain with cnt[1]=2 -> all outputs 0 in the same cycle; after release, a consumer of R1 does not stall.
